// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side request/accept bus and UART transmitter
// strobe/data bundle for the shared-UART arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic [1:0]  grant_id;
  logic        busy;

  // Requesters / environment side
  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data, tx_en, grant_id, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data, tx_en, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among 4 requesters.
// The transmitter has no busy flag, so each frame is self-timed with a
// FRAME_CYCLES counter. Arbitration is round-robin by default; defining
// UART_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) and
// removes the round-robin pointer.
module uart_tx_arbiter #(
  parameter int unsigned SYS_CLK_FRP = 50_000_000,
  parameter int unsigned BAUDRATE    = 9600,
  parameter int unsigned FRAME_BITS  = 10
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned FRAME_CYCLES = (SYS_CLK_FRP / BAUDRATE) * FRAME_BITS;
  localparam int unsigned CNT_W        = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  // WAIT lasts FRAME_CYCLES-1 cycles: counter runs 0 .. FRAME_CYCLES-2
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, GRANT, START, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       req_ready_nxt;
  logic             tx_en_nxt;
  logic [7:0]       tx_data_nxt;
  logic [1:0]       grant_id_nxt;
  logic             busy_nxt;
  logic [1:0]       winner_c;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index active requester wins
  always_comb begin
    winner_c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req_valid[i]) winner_c = 2'(i);
    end
  end
`else
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] dbl_c;
  logic [3:0] rot_c;

  // Round-robin: rotate requests so ptr is bit 0, pick first set, rotate back
  always_comb begin
    dbl_c    = {bus.req_valid, bus.req_valid} >> ptr;
    rot_c    = dbl_c[3:0];
    winner_c = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (rot_c[i]) winner_c = ptr + 2'(i);
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_ready_nxt = 4'b0000;
    tx_en_nxt     = 1'b0;
    tx_data_nxt   = bus.tx_data;
    grant_id_nxt  = bus.grant_id;
`ifndef UART_ARB_FIXED_PRIO_EN
    ptr_nxt       = ptr;
`endif
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_id_nxt  = winner_c;
          req_ready_nxt = 4'b0001 << winner_c;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        // Transfer only if the requester still holds its request
        if (bus.req_valid[bus.grant_id]) begin
          tx_data_nxt = bus.req_data[{bus.grant_id, 3'b000} +: 8];
          tx_en_nxt   = 1'b1;
          state_nxt   = START;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_nxt     = bus.grant_id + 2'd1;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 4'b0000;
      bus.tx_en     <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.grant_id  <= 2'd0;
      bus.busy      <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr           <= 2'd0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.req_ready <= req_ready_nxt;
      bus.tx_en     <= tx_en_nxt;
      bus.tx_data   <= tx_data_nxt;
      bus.grant_id  <= grant_id_nxt;
      bus.busy      <= busy_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr           <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a timeline-based reference
// model checked every cycle, plus literal expectations for the key scenarios.
// Clock/baud are scaled so one frame is 100 cycles (1000/100*10).
module tb_uart_tx_arbiter;

  localparam int FC = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .SYS_CLK_FRP (1000),
    .BAUDRATE    (100),
    .FRAME_BITS  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event timeline) ----------------
  int         edge_n      = 0;
  int         next_sample = -1;
  int         check_edge  = -1;
  int         busy_end    = 0;
  logic [1:0] m_ptr       = 2'd0;
  logic [1:0] m_win       = 2'd0;
  logic       model_on    = 1'b0;
  logic [3:0] exp_ready   = 4'b0;
  logic       exp_en      = 1'b0;
  logic [7:0] exp_data    = 8'h00;
  logic [1:0] exp_gid     = 2'd0;
  logic       exp_busy    = 1'b0;

  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
    logic found;
    int   idx;
    pick  = 2'd0;
    found = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
    idx = int'(p);
    for (int k = 0; k < 4; k++) begin
      if (v[k] && !found) begin found = 1'b1; pick = 2'(k); end
    end
`else
    for (int k = 0; k < 4; k++) begin
      idx = (int'(p) + k) % 4;
      if (v[idx] && !found) begin found = 1'b1; pick = 2'(idx); end
    end
`endif
  endfunction

  // Model: at each edge decide what the outputs after that edge must be
  always @(posedge clk) begin
    edge_n++;
    exp_ready = 4'b0;
    exp_en    = 1'b0;
    if (rst) begin
      model_on    = 1'b1;
      exp_data    = 8'h00;
      exp_gid     = 2'd0;
      m_ptr       = 2'd0;
      next_sample = edge_n + 1;
      check_edge  = -1;
      busy_end    = edge_n;
    end else if (model_on) begin
      if (edge_n == next_sample) begin
        if (bus.req_valid != 4'b0) begin
          m_win      = pick(bus.req_valid, m_ptr);
          exp_gid    = m_win;
          exp_ready  = 4'b0001 << m_win;
          check_edge = edge_n + 1;
          busy_end   = edge_n + 2;
        end else begin
          next_sample = edge_n + 1;
        end
      end else if (edge_n == check_edge) begin
        if (bus.req_valid[m_win]) begin
          exp_en      = 1'b1;
          exp_data    = bus.req_data[8*m_win +: 8];
          m_ptr       = m_win + 2'd1;
          busy_end    = edge_n + FC;
          next_sample = edge_n + FC + 1;
        end else begin
          busy_end    = edge_n;
          next_sample = edge_n + 1;
        end
      end
    end
    exp_busy = (edge_n < busy_end);
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (model_on) begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("tx_en",     32'(bus.tx_en),     32'(exp_en));
      check("tx_data",   32'(bus.tx_data),   32'(exp_data));
      check("grant_id",  32'(bus.grant_id),  32'(exp_gid));
      check("busy",      32'(bus.busy),      32'(exp_busy));
      check("ready_tx_excl", 32'((|bus.req_ready) && bus.tx_en), 32'd0);
      check("ready_onehot",  32'($countones(bus.req_ready) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tx(output logic [7:0] d, output int t);
    logic seen;
    seen = 1'b0;
    d = 8'h00;
    t = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (bus.tx_en) begin seen = 1'b1; d = bus.tx_data; t = edge_n; end
    end
    if (!seen) check("timeout_tx_en", 32'd0, 32'd1);
  endtask

  task automatic wait_ready();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.req_ready != 4'b0) seen = 1'b1;
    end
    if (!seen) check("timeout_req_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (!bus.busy) seen = 1'b1;
    end
    if (!seen) check("timeout_idle", 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_tx_en"}, 32'(bus.tx_en),     32'd0);
    check({tag, "_data"},  32'(bus.tx_data),   32'd0);
    check({tag, "_gid"},   32'(bus.grant_id),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0] d;
  int         t, t_prev;
  logic [7:0] exp_seq [5];

  initial begin
    bus.req_valid = 4'b0;
    bus.req_data  = 32'h0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Single requester 0 with 0x55
    bus.req_data  = 32'h0000_0055;
    bus.req_valid = 4'b0001;
    wait_ready();
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("single_tx_en", 32'(bus.tx_en), 32'd1);
    check("single_data",  32'(bus.tx_data), 32'h55);
    bus.req_valid = 4'b0;
    t = edge_n;
    wait_idle();
    check("single_busy_len", 32'(edge_n - t), 32'(FC));

    // All four requesting: rotation order and pulse spacing
    pulse_rst();
    bus.req_data  = 32'hA3A2_A1A0;
    bus.req_valid = 4'hF;
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_seq = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
`else
    exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
`endif
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_tx(d, t);
      check("rr_data", 32'(d), 32'(exp_seq[k]));
      if (k > 0) check("rr_spacing", 32'(t - t_prev), 32'(FC + 2));
      t_prev = t;
    end
    bus.req_valid = 4'b0;
    wait_idle();

    // Pointer wrap after requester 2
    pulse_rst();
    bus.req_data  = 32'h4433_2211;
    bus.req_valid = 4'b0100;
    wait_tx(d, t);
    check("wrap_first", 32'(d), 32'h33);
    bus.req_valid = 4'b0101;
    wait_tx(d, t);
    check("wrap_second", 32'(d), 32'h11);
    wait_tx(d, t);
`ifdef UART_ARB_FIXED_PRIO_EN
    check("wrap_third", 32'(d), 32'h11);
`else
    check("wrap_third", 32'(d), 32'h33);
`endif
    bus.req_valid = 4'b0;
    wait_idle();

    // Request withdrawn during GRANT
    pulse_rst();
    bus.req_data  = 32'h00C2_B100;
    bus.req_valid = 4'b0010;
    wait_ready();
    check("drop_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 4'b0;
    tick();
    check("drop_no_tx", 32'(bus.tx_en), 32'd0);
    check("drop_busy",  32'(bus.busy),  32'd0);
    repeat (3) tick();
    bus.req_valid = 4'b0110;
    wait_tx(d, t);
    check("drop_next_first", 32'(d), 32'hB1);
    bus.req_valid = 4'b0;
    wait_idle();

    // Reset in the middle of WAIT, pending requester 3
    pulse_rst();
    bus.req_data  = 32'hD300_0000;
    bus.req_valid = 4'b1000;
    wait_tx(d, t);
    check("midrst_first", 32'(d), 32'hD3);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    wait_tx(d, t);
    check("midrst_regrant", 32'(d), 32'hD3);
    check("midrst_gid", 32'(bus.grant_id), 32'd3);
    bus.req_valid = 4'b0;
    wait_idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter SYS_CLK_FRP, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, UART bit rate.
REQ-003 Parameter FRAME_BITS, default 10, bits per UART frame (start + 8 data + stop).
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset: synchronous, active-high.
REQ-006 Port req_valid  input  4  per-requester send request; bit i = requester i.
REQ-007 Port req_data  input  32  packed bytes; requester i at bits [8i+7:8i].
REQ-008 Port req_ready  output  4  one-hot, one-cycle accept strobe to granted requester.
REQ-009 Port tx_data  output  8  byte to the UART transmitter.
REQ-010 Port tx_en  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 Port grant_id  output  2  index of last granted requester.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL share one UART transmitter among 4 requesters; the transmitter has no busy output, so frame completion SHALL be self-timed.
REQ-014 FRAME_CYCLES SHALL equal (SYS_CLK_FRP / BAUDRATE, integer division) * FRAME_BITS; 52080 at defaults; counter width sized to hold it.
REQ-015 FSM states: IDLE, GRANT, START, WAIT; all outputs registered.
REQ-016 IDLE: if any req_valid bit is high, select a winner, load grant_id, go to GRANT; otherwise stay.
REQ-017 Round-robin: search starts at pointer ptr and wraps 3->0; after a completed grant, ptr = winner+1 mod 4 (3 wraps to 0).
REQ-018 GRANT: req_ready[grant_id]=1 for exactly this cycle; if req_valid[grant_id] is still high, capture its byte into tx_data and go to START; else no transfer, ptr unchanged, return to IDLE.
REQ-019 START: tx_en=1 for exactly one cycle; tx_data held stable from START until the next capture.
REQ-020 WAIT: count FRAME_CYCLES-1 cycles, then go to IDLE; req_valid is ignored during WAIT.
REQ-021 Under continuous demand, tx_en pulses SHALL be spaced exactly FRAME_CYCLES+2 cycles (52082 at defaults).
REQ-022 Requesters SHALL hold req_valid and req_data until req_ready; data is taken only in the GRANT cycle.
REQ-023 req_ready and tx_en SHALL never be high in the same cycle; at most one req_ready bit is high.

Reset
REQ-024 rst high at a clock edge SHALL force: state=IDLE, ptr=0, req_ready=0, tx_en=0, tx_data=0x00, grant_id=0, busy=0, frame counter=0.
REQ-025 Reset mid-GRANT or mid-WAIT SHALL abandon the transfer with no tx_en issued afterward; arbitration restarts from ptr=0.
REQ-026 rst has priority over all other inputs in the same cycle.

Configuration
REQ-027 Macro UART_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (requester 0 highest, 3 lowest) and ptr is not implemented.
REQ-028 Without UART_ARB_FIXED_PRIO_EN, round-robin per REQ-017 applies; all other behaviour is identical in both builds.

Verification
REQ-029 Only req_valid[0], req_data[7:0]=0x55 -> req_ready=4'b0001 for 1 cycle, next cycle tx_en=1 with tx_data=0x55, busy low 52080 cycles after tx_en.
REQ-030 req_valid=4'hF held, bytes 0xA0..0xA3 -> tx_en order 0xA0,0xA1,0xA2,0xA3,0xA0, consecutive pulses 52082 cycles apart.
REQ-031 After requester 2 is served, req_valid=4'b0101 -> requester 0 (wrap) granted before requester 2.
REQ-032 req_valid[1] dropped in its GRANT cycle -> no tx_en, busy low next cycle, requester 1 still first in the next round.
REQ-033 rst pulsed 1000 cycles into WAIT -> all outputs at reset values next cycle; pending req_valid=4'b1000 re-granted starting from ptr=0.
REQ-034 UART_ARB_FIXED_PRIO_EN defined, req_valid=4'hF held -> every tx_en carries requester 0's byte.
